// File: rtl/grf_ctx_seq.sv
// grf_ctx_seq: sequences a register-file context save (RF -> stream) or restore (stream -> RF).
// Define GRF_CTX_CHECKSUM_EN to add an XOR checksum trailer word to both directions.
module grf_ctx_seq #(
  parameter int unsigned NREGS = 16
) (
  input  logic        i_clk,
  input  logic        i_rst_b,
  input  logic        i_clk_en,
  input  logic        i_save_req,
  input  logic        i_restore_req,
  output logic        o_busy,
  output logic        o_done,
  output logic [3:0]  o_rf_raddr,
  input  logic [31:0] i_rf_dout,
  output logic [3:0]  o_rf_waddr,
  output logic [3:0]  o_rf_wen,
  output logic        o_rf_cs_b,
  output logic [31:0] o_rf_din,
  output logic [31:0] o_st_data,
  output logic        o_st_valid,
  input  logic        i_st_ready,
  input  logic [31:0] i_ld_data,
  input  logic        i_ld_valid,
  output logic        o_ld_ready
`ifdef GRF_CTX_CHECKSUM_EN
  ,
  output logic [31:0] o_csum,
  output logic        o_csum_err
`endif
);

  typedef enum logic [2:0] {
    StIdle,
    StSave,
    StRestore,
    StDone
`ifdef GRF_CTX_CHECKSUM_EN
    ,
    StCsum
`endif
  } state_e;

`ifdef GRF_CTX_CHECKSUM_EN
  localparam state_e StPost = StCsum;
`else
  localparam state_e StPost = StDone;
`endif

  // idx is one bit wider than the address so NREGS=16 can reach its end count without wrapping
  localparam logic [4:0] IdxEnd  = 5'(NREGS);
  localparam logic [4:0] IdxLast = 5'(NREGS - 1);

  state_e      state_q, state_d;
  logic [4:0]  idx_q;
  logic [31:0] st_data_q;
  logic        st_valid_q;
  logic        start, st_free, save_load, save_exit, ld_fire, ld_last;

  assign start     = i_clk_en && (state_q == StIdle) && (i_save_req || i_restore_req);
  assign st_free   = !st_valid_q || i_st_ready;
  assign save_load = i_clk_en && (state_q == StSave) && st_free && (idx_q < IdxEnd);
  assign save_exit = i_clk_en && (state_q == StSave) && (idx_q == IdxEnd) && st_valid_q &&
                     i_st_ready;
  assign ld_fire   = i_clk_en && (state_q == StRestore) && i_ld_valid;
  assign ld_last   = ld_fire && (idx_q == IdxLast);

  assign o_rf_raddr = idx_q[3:0];
  assign o_st_data  = st_data_q;
  assign o_st_valid = st_valid_q;

`ifdef GRF_CTX_CHECKSUM_EN
  logic        op_save_q;
  logic [31:0] csum_q;
  logic        csum_err_q;
  logic        cs_load, cs_sent, cs_chk;

  assign cs_load    = i_clk_en && (state_q == StCsum) && op_save_q && !st_valid_q;
  assign cs_sent    = i_clk_en && (state_q == StCsum) && op_save_q && st_valid_q && i_st_ready;
  assign cs_chk     = i_clk_en && (state_q == StCsum) && !op_save_q && i_ld_valid;
  assign o_csum     = csum_q;
  assign o_csum_err = csum_err_q;
`endif

  always_ff @(posedge i_clk or negedge i_rst_b) begin
    if (!i_rst_b) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:    if (start) state_d = i_save_req ? StSave : StRestore;
      StSave:    if (save_exit) state_d = StPost;
      StRestore: if (ld_last) state_d = StPost;
`ifdef GRF_CTX_CHECKSUM_EN
      StCsum:    if (cs_sent || cs_chk) state_d = StDone;
`endif
      StDone:    if (i_clk_en) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_comb begin
    o_busy     = (state_q != StIdle);
    o_done     = (state_q == StDone);
    o_ld_ready = i_clk_en && (state_q == StRestore);
`ifdef GRF_CTX_CHECKSUM_EN
    if (i_clk_en && (state_q == StCsum) && !op_save_q) o_ld_ready = 1'b1;
`endif
    o_rf_cs_b  = !ld_fire;
    o_rf_wen   = ld_fire ? 4'hF : 4'h0;
    o_rf_waddr = ld_fire ? idx_q[3:0] : 4'h0;
    o_rf_din   = ld_fire ? i_ld_data : 32'h0;
  end

  always_ff @(posedge i_clk or negedge i_rst_b) begin
    if (!i_rst_b) begin
      idx_q      <= '0;
      st_data_q  <= '0;
      st_valid_q <= 1'b0;
`ifdef GRF_CTX_CHECKSUM_EN
      op_save_q  <= 1'b0;
      csum_q     <= '0;
      csum_err_q <= 1'b0;
`endif
    end else begin
      if (start) begin
        idx_q      <= '0;
`ifdef GRF_CTX_CHECKSUM_EN
        op_save_q  <= i_save_req;
        csum_q     <= '0;
        csum_err_q <= 1'b0;
`endif
      end
      if (save_load) begin
        st_data_q  <= i_rf_dout;
        st_valid_q <= 1'b1;
        idx_q      <= idx_q + 5'd1;
`ifdef GRF_CTX_CHECKSUM_EN
        csum_q     <= csum_q ^ i_rf_dout;
`endif
      end else if (save_exit) begin
        st_valid_q <= 1'b0;
      end
      if (ld_fire) begin
        idx_q  <= idx_q + 5'd1;
`ifdef GRF_CTX_CHECKSUM_EN
        csum_q <= csum_q ^ i_ld_data;
`endif
      end
`ifdef GRF_CTX_CHECKSUM_EN
      if (cs_load) begin
        st_data_q  <= csum_q;
        st_valid_q <= 1'b1;
      end else if (cs_sent) begin
        st_valid_q <= 1'b0;
      end
      if (cs_chk) csum_err_q <= (i_ld_data != csum_q);
`endif
    end
  end

endmodule

// File: tb/tb_grf_ctx_seq.sv
// Bench for grf_ctx_seq: directed scenarios plus randomized save/restore traffic,
// checked every cycle against a transaction-level model of the sequencer.
module tb_grf_ctx_seq;
  localparam int N = 16;

  logic        clk = 1'b0;
  logic        rst_b = 1'b0;
  logic        en = 1'b0;
  logic        save_req = 1'b0;
  logic        restore_req = 1'b0;
  logic        st_ready = 1'b0;
  logic [31:0] ld_data = '0;
  logic        ld_valid = 1'b0;
  logic        o_busy, o_done, o_rf_cs_b, o_st_valid, o_ld_ready;
  logic [3:0]  o_rf_raddr, o_rf_waddr, o_rf_wen;
  logic [31:0] rf_dout, o_rf_din, o_st_data;
`ifdef GRF_CTX_CHECKSUM_EN
  logic [31:0] o_csum;
  logic        o_csum_err;
  localparam int TRL = 1;
`else
  localparam int TRL = 0;
`endif

  logic [31:0] rf [N];

  grf_ctx_seq #(.NREGS(N)) dut (
    .i_clk(clk), .i_rst_b(rst_b), .i_clk_en(en),
    .i_save_req(save_req), .i_restore_req(restore_req),
    .o_busy(o_busy), .o_done(o_done),
    .o_rf_raddr(o_rf_raddr), .i_rf_dout(rf_dout),
    .o_rf_waddr(o_rf_waddr), .o_rf_wen(o_rf_wen), .o_rf_cs_b(o_rf_cs_b), .o_rf_din(o_rf_din),
    .o_st_data(o_st_data), .o_st_valid(o_st_valid), .i_st_ready(st_ready),
    .i_ld_data(ld_data), .i_ld_valid(ld_valid), .o_ld_ready(o_ld_ready)
`ifdef GRF_CTX_CHECKSUM_EN
    , .o_csum(o_csum), .o_csum_err(o_csum_err)
`endif
  );

  always #5 clk = ~clk;

  // Register file environment: asynchronous read, byte-enabled synchronous write.
  assign rf_dout = rf[o_rf_raddr];
  always @(posedge clk) begin
    if (!o_rf_cs_b) begin
      for (int b = 0; b < 4; b++)
        if (o_rf_wen[b]) rf[o_rf_waddr][8*b +: 8] <= o_rf_din[8*b +: 8];
    end
  end

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- transaction-level reference model + per-cycle compare ----------------
  typedef enum int {MIdle, MSave, MRest, MRestTrl, MDone} mode_t;
  mode_t       mode = MIdle;
  logic [31:0] exp_q[$];
  logic [31:0] acc_log[$];
  int          acc_cyc[$];
  logic [31:0] ref_rf [N];
  int          wcnt = 0;
  logic [31:0] xsum = '0;
  logic        m_err = 1'b0;
  bit          prev_hold = 0;
  logic [31:0] prev_d = '0;

  initial begin
    logic we, sh;
    logic [31:0] w;
    forever begin
      @(negedge clk);
      #4;
      cyc++;
      if (!rst_b) begin
        chk("rst_busy", 32'(o_busy), 0);
        chk("rst_done", 32'(o_done), 0);
        chk("rst_st_valid", 32'(o_st_valid), 0);
        chk("rst_st_data", o_st_data, 0);
        chk("rst_ld_ready", 32'(o_ld_ready), 0);
        chk("rst_cs_b", 32'(o_rf_cs_b), 1);
        chk("rst_wen", 32'(o_rf_wen), 0);
        chk("rst_waddr", 32'(o_rf_waddr), 0);
        chk("rst_din", o_rf_din, 0);
        chk("rst_raddr", 32'(o_rf_raddr), 0);
`ifdef GRF_CTX_CHECKSUM_EN
        chk("rst_csum", o_csum, 0);
        chk("rst_csum_err", 32'(o_csum_err), 0);
`endif
        mode = MIdle; exp_q.delete(); prev_hold = 0; m_err = 1'b0; xsum = '0;
      end else begin
        we = en && (mode == MRest) && ld_valid;
        sh = en && o_st_valid && st_ready;
        chk("busy", 32'(o_busy), 32'(mode != MIdle));
        chk("done", 32'(o_done), 32'(mode == MDone));
        chk("ld_ready", 32'(o_ld_ready), 32'(en && (mode == MRest || mode == MRestTrl)));
        chk("rf_cs_b", 32'(o_rf_cs_b), 32'(!we));
        chk("rf_wen", 32'(o_rf_wen), we ? 32'hF : 32'h0);
        chk("rf_waddr", 32'(o_rf_waddr), we ? 32'(wcnt) : 32'h0);
        chk("rf_din", o_rf_din, we ? ld_data : 32'h0);
        if (mode == MRest) chk("rf_raddr", 32'(o_rf_raddr), 32'(wcnt % 16));
        if (mode != MSave) chk("st_valid_idle", 32'(o_st_valid), 0);
        if (prev_hold) begin
          chk("st_hold_valid", 32'(o_st_valid), 1);
          chk("st_hold_data", o_st_data, prev_d);
        end
`ifdef GRF_CTX_CHECKSUM_EN
        chk("csum_err", 32'(o_csum_err), 32'(m_err));
        if (mode == MIdle || mode == MDone) chk("csum", o_csum, xsum);
`endif
        if (sh) begin
          acc_log.push_back(o_st_data);
          acc_cyc.push_back(cyc);
          if (mode == MSave && exp_q.size() > 0) begin
            w = exp_q.pop_front();
            chk("st_word", o_st_data, w);
          end else begin
            n_checks++; n_fail++;
            $display("FAIL st_extra: got %08h expected no word (cycle %0d)", o_st_data, cyc);
          end
        end
        prev_hold = o_st_valid && !sh;
        prev_d = o_st_data;
        if (en) begin
          case (mode)
            MIdle: begin
              if (save_req || restore_req) begin
                xsum = '0; m_err = 1'b0; wcnt = 0;
              end
              if (save_req) begin
                exp_q.delete();
                for (int i = 0; i < N; i++) begin
                  exp_q.push_back(rf[i]);
                  xsum ^= rf[i];
                end
                if (TRL != 0) exp_q.push_back(xsum);
                mode = MSave;
              end else if (restore_req) begin
                mode = MRest;
              end
            end
            MSave: if (sh && exp_q.size() == 0) mode = MDone;
            MRest: if (we) begin
              ref_rf[wcnt] = ld_data;
              xsum ^= ld_data;
              wcnt++;
              if (wcnt == N) mode = (TRL != 0) ? MRestTrl : MDone;
            end
            MRestTrl: if (ld_valid) begin
              m_err = (ld_data != xsum);
              mode = MDone;
            end
            default: mode = MIdle;
          endcase
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  int busy_cnt = 0;
  int wr_cnt = 0;
  bit s_ld_hs, s_done, s_en, s_wr;

  task automatic tick();
    #4;
    s_ld_hs = ld_valid && o_ld_ready;
    s_done = o_done;
    s_en = en;
    s_wr = !o_rf_cs_b;
    if (o_busy && en) busy_cnt++;
    if (!o_rf_cs_b) wr_cnt++;
    @(negedge clk);
  endtask

  // kind: 0 save, 1 restore, 2 both requests. p_rdy < 0 selects the 1,0,0,1 ready pattern.
  // trl_mode: 0 correct trailer, 1 literal trl_val, 2 corrupted trailer. stray: 1 random, 2 held restore.
  task automatic run_op(input int kind, input int p_en, input int p_rdy, input int p_vld,
                        input bit dpat, input logic [31:0] dbase, input int trl_mode,
                        input logic [31:0] trl_val, input int stray, input int stall_at);
    int k = 0;
    int g = 0;
    int stall = 0;
    int pat = 0;
    bit stalled = 0;
    bit fin = 0;
    bit st_cyc;
    logic [3:0] rp = 4'b1001;
    logic [31:0] sx = '0;
    logic [31:0] w;
    busy_cnt = 0; wr_cnt = 0;
    acc_log.delete(); acc_cyc.delete();
    en = 1'b1; save_req = (kind != 1); restore_req = (kind != 0);
    st_ready = 1'b1; ld_valid = 1'b0;
    tick();
    save_req = 1'b0; restore_req = 1'b0;
    while (!fin && g < 2000) begin
      g++;
      if (!stalled && stall_at >= 0 && k == stall_at) begin stall = 3; stalled = 1; end
      st_cyc = (stall > 0);
      if (stall > 0) begin en = 1'b0; stall--; end
      else en = ($urandom_range(99) < 32'(p_en));
      st_ready = (p_rdy < 0) ? rp[pat % 4] : ($urandom_range(99) < 32'(p_rdy));
      pat++;
      ld_valid = ($urandom_range(99) < 32'(p_vld));
      if (k < N) w = dpat ? dbase + 32'(k) : $urandom();
      else w = (trl_mode == 0) ? sx : (trl_mode == 1) ? trl_val : (sx ^ 32'h0000_0100);
      ld_data = w;
      save_req = 1'b0; restore_req = 1'b0;
      if (o_busy && !o_done) begin
        if (stray == 1) begin
          save_req = ($urandom_range(9) == 0);
          restore_req = ($urandom_range(9) == 0);
        end else if (stray == 2) begin
          restore_req = 1'b1;
        end
      end
      tick();
      if (st_cyc) chk("stall_no_write", 32'(s_wr), 0);
      if (s_ld_hs) begin
        if (k < N) sx ^= w;
        k++;
      end
      if (s_done && s_en) fin = 1;
    end
    en = 1'b1; save_req = 1'b0; restore_req = 1'b0; ld_valid = 1'b0; st_ready = 1'b0;
    if (!fin) begin
      n_checks++; n_fail++;
      $display("FAIL op_timeout: got no done pulse expected done within 2000 cycles");
    end
    repeat (2) tick();
  endtask

  task automatic chk_rf_model();
    for (int i = 0; i < N; i++) chk("rf_vs_model", rf[i], ref_rf[i]);
  endtask

  initial begin
    @(negedge clk);
    repeat (3) tick();
    rst_b = 1'b1;
    tick();

    // Preload R[n] = 1000_0000+n through a restore.
    run_op(1, 100, 100, 100, 1, 32'h1000_0000, 0, 0, 0, -1);
    chk("preload_writes", 32'(wr_cnt), 32'(N));

    // Continuous-ready save: 16 words on consecutive cycles.
    run_op(0, 100, 100, 100, 0, 0, 0, 0, 0, -1);
    chk("save_busy_cycles", 32'(busy_cnt), 32'(N + 2 + 2 * TRL));
    chk("save_words", 32'(acc_log.size()), 32'(N + TRL));
    if (acc_log.size() >= N) begin
      for (int i = 0; i < N; i++) begin
        chk("save_word_lit", acc_log[i], 32'h1000_0000 + 32'(i));
        chk("save_consecutive", 32'(acc_cyc[i] - acc_cyc[0]), 32'(i));
      end
    end
    if (TRL != 0 && acc_log.size() == N + 1) chk("save_trailer_lit", acc_log[N], 32'h0);

    // Ready toggling 1,0,0,1: no loss or duplication.
    run_op(0, 100, -1, 100, 0, 0, 0, 0, 0, -1);
    chk("stall_save_words", 32'(acc_log.size()), 32'(N + TRL));
    if (acc_log.size() >= N)
      for (int i = 0; i < N; i++) chk("stall_save_lit", acc_log[i], 32'h1000_0000 + 32'(i));

    // Both requests: save wins; restore held high during save is ignored.
    run_op(2, 100, 100, 100, 0, 0, 0, 0, 2, -1);
    chk("both_save_words", 32'(acc_log.size()), 32'(N + TRL));
    chk("both_no_writes", 32'(wr_cnt), 0);
    if (acc_log.size() > 0) chk("both_first_word", acc_log[0], 32'h1000_0000);

    // Restore A5A5_0000+n with continuous valid.
    run_op(1, 100, 100, 100, 1, 32'hA5A5_0000, 0, 0, 0, -1);
    chk("restore_wr_cycles", 32'(wr_cnt), 32'(N));
    for (int i = 0; i < N; i++) chk("restore_lit", rf[i], 32'hA5A5_0000 + 32'(i));

    // Clock enable low for 3 cycles after 5 writes.
    run_op(1, 100, 100, 100, 1, 32'h5000_0000, 0, 0, 0, 5);
    chk("stall_restore_wr", 32'(wr_cnt), 32'(N));
    for (int i = 0; i < N; i++) chk("stall_restore_lit", rf[i], 32'h5000_0000 + 32'(i));

`ifdef GRF_CTX_CHECKSUM_EN
    run_op(1, 100, 100, 100, 1, 32'h0, 1, 32'h0, 0, -1);
    chk("csum_good_err", 32'(o_csum_err), 0);
    run_op(1, 100, 100, 100, 1, 32'h0, 1, 32'h1, 0, -1);
    chk("csum_bad_err", 32'(o_csum_err), 1);
`endif

    for (int t = 0; t < 40; t++) begin
      run_op(int'($urandom_range(2)), 60 + int'($urandom_range(40)), 20 + int'($urandom_range(80)),
             20 + int'($urandom_range(80)), 0, 0, ($urandom_range(1) == 0) ? 0 : 2, 0, 1, -1);
      chk_rf_model();
    end

    // Asynchronous reset in the middle of a restore.
    en = 1'b1; restore_req = 1'b1; ld_valid = 1'b1; ld_data = 32'hDEAD_0000;
    tick();
    restore_req = 1'b0;
    repeat (4) tick();
    #2 rst_b = 1'b0;
    #1;
    chk("async_rst_busy", 32'(o_busy), 0);
    chk("async_rst_cs_b", 32'(o_rf_cs_b), 1);
    chk("async_rst_ld_ready", 32'(o_ld_ready), 0);
    @(negedge clk);
    wr_cnt = 0;
    repeat (2) tick();
    rst_b = 1'b1;
    repeat (5) tick();
    chk("abort_no_writes", 32'(wr_cnt), 0);
    chk("abort_no_resume", 32'(o_busy), 0);
    chk("abort_partial_rf", rf[0], 32'hDEAD_0000);
    chk_rf_model();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got simulation still running expected finish");
    $fatal(1, "watchdog");
  end

endmodule
